// File: rtl/and_operand_loader.sv
// Serial-to-parallel loader: collects 8 operands into slots a..h and holds them for the AND stage.
// Optional running-AND register acc_q is enabled with `define AND_LOADER_ACC_EN.
module and_operand_loader #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] acc_q
);

    generate
        if (NUM_OPS != 8) begin : g_num_ops_check
            $error("and_operand_loader: NUM_OPS must be 8 to match ports a..h");
        end
    endgenerate

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_slot [8];

    logic             w_in_ready;
    logic             w_beat;
    logic [2:0]       w_wr_idx;

    // In HOLD a beat is only taken when the held group leaves in the same cycle.
    always_comb begin
        w_in_ready = rst_n & ~clear & ((r_state == S_FILL) | out_ready);
        w_beat     = in_valid & w_in_ready;
        w_wr_idx   = (r_state == S_HOLD) ? 3'd0 : r_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            if (w_beat) begin
                r_slot[w_wr_idx] <= in_data;
            end
            case (r_state)
                S_FILL: begin
                    if (clear) begin
                        r_cnt <= 3'd0;
                    end else if (w_beat) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_FILL;
                        r_out_valid <= 1'b0;
                        r_cnt       <= w_beat ? 3'd1 : 3'd0;
                    end
                end
                default: begin
                    r_state     <= S_FILL;
                    r_cnt       <= 3'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AND_LOADER_ACC_EN
    logic [WIDTH-1:0] r_acc;

    // Restart from all-ones whenever a new group begins; an overlap beat seeds it directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '1;
        end else if (r_state == S_FILL) begin
            if (clear) begin
                r_acc <= '1;
            end else if (w_beat) begin
                r_acc <= r_acc & in_data;
            end
        end else if (out_ready) begin
            r_acc <= w_beat ? in_data : '1;
        end
    end

    assign acc_q = r_acc;
`else
    assign acc_q = '1;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign a = r_slot[0];
    assign b = r_slot[1];
    assign c = r_slot[2];
    assign d = r_slot[3];
    assign e = r_slot[4];
    assign f = r_slot[5];
    assign g = r_slot[6];
    assign h = r_slot[7];

endmodule

// File: tb/tb_and_operand_loader.sv
// Scoreboard bench for and_operand_loader: driver queues expected groups, monitor checks each held group.
module tb_and_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a, b, c, d, e, f, g, h, acc_q;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0][7:0] s;
        logic [7:0]      acc;
    } grp_t;

    grp_t sb_q[$];

    and_operand_loader #(.WIDTH(8), .NUM_OPS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .acc_q(acc_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_acc(input logic [7:0][7:0] grp);
        logic [7:0] r;
        r = 8'hFF;
`ifdef AND_LOADER_ACC_EN
        for (int i = 0; i < 8; i++) r = r & grp[i];
`endif
        return r;
    endfunction

    // Monitor: a new group is popped when out_valid rises, then checked every held cycle.
    initial begin
        logic prev_valid;
        logic have_cur;
        grp_t cur;
        prev_valid = 1'b0;
        have_cur   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (!prev_valid) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        have_cur = 1'b0;
                        $display("FAIL sb_unexpected_group: got group %0h expected none", {h, g, f, e, d, c, b, a});
                    end else begin
                        cur      = sb_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    check("group_slots", {h, g, f, e, d, c, b, a}, cur.s);
                    check("group_acc", acc_q, cur.acc);
                end
            end
            prev_valid = out_valid;
        end
    end

    // One cycle of stimulus; in_ready is checked just before the edge.
    task automatic cyc_drive(input logic v, input logic [7:0] dat, input logic ordy,
                             input logic clr, input logic exp_rdy);
        @(negedge clk);
        in_valid  = v;
        in_data   = dat;
        out_ready = ordy;
        clear     = clr;
        #1;
        check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    // Fill a full group; with ovl set the first beat overlaps the release of the held group.
    task automatic fill_group(input logic [7:0][7:0] grp, input logic ovl);
        grp_t item;
        item.s   = grp;
        item.acc = exp_acc(grp);
        sb_q.push_back(item);
        for (int i = 0; i < 8; i++) begin
            cyc_drive(1'b1, grp[i], (i == 0) && ovl, 1'b0, 1'b1);
            if (i == 0 && ovl) begin
                check("ovl_out_valid_low", out_valid, 1'b0);
                check("ovl_slot_a", a, grp[0]);
            end
            if (i < 7) check("fill_out_valid_low", out_valid, 1'b0);
            else       check("latency_out_valid", out_valid, 1'b1);
        end
    endtask

    task automatic release_group();
        cyc_drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("release_out_valid", out_valid, 1'b0);
        #1;
        check("release_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0][7:0] grp;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0; out_ready = 1'b0;

        // Reset: in_ready forced low, reset state visible
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h77;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_slots", {h, g, f, e, d, c, b, a}, 64'h0);
        check("rst_acc", acc_q, 8'hFF);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Test 1: beats 01..08, held with out_ready low
        for (int i = 0; i < 8; i++) grp[i] = 8'h01 + 8'(i);
        fill_group(grp, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc_drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
            check("hold_out_valid", out_valid, 1'b1);
        end

        // Test 2: release without a beat, then a fresh group starts at slot a
        release_group();
        for (int i = 0; i < 8; i++) grp[i] = 8'h11 + 8'(i);
        fill_group(grp, 1'b0);

        // Test 3: overlap beat 0x55 during release, 7 more beats complete the group
        for (int i = 0; i < 8; i++) grp[i] = 8'h55 + 8'(i);
        fill_group(grp, 1'b1);
        release_group();

        // Test 4: clear after 3 beats blocks the simultaneous beat and restarts at slot a
        cyc_drive(1'b1, 8'h21, 1'b0, 1'b0, 1'b1);
        cyc_drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        cyc_drive(1'b1, 8'h23, 1'b0, 1'b0, 1'b1);
        cyc_drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        check("clear_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 8; i++) grp[i] = 8'h31 + 8'(i);
        fill_group(grp, 1'b0);

        // clear in HOLD: group still released, overlap beat blocked
        cyc_drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        check("hold_clear_release", out_valid, 1'b0);

        // Test 6: accumulator pattern
        grp = {8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3C, 8'hF0, 8'hFF};
        begin
            grp_t item;
            item.s   = grp;
`ifdef AND_LOADER_ACC_EN
            item.acc = 8'h30;
`else
            item.acc = 8'hFF;
`endif
            sb_q.push_back(item);
        end
        for (int i = 0; i < 8; i++) begin
            cyc_drive(1'b1, grp[i], 1'b0, 1'b0, 1'b1);
`ifdef AND_LOADER_ACC_EN
            if (i == 1) check("acc_mid_fill", acc_q, 8'hF0);
`else
            if (i == 1) check("acc_mid_fill", acc_q, 8'hFF);
`endif
        end
        check("acc_group_latency", out_valid, 1'b1);

        // Test 5: reset while holding discards the group
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("hold_rst_out_valid", out_valid, 1'b0);
        check("hold_rst_slots", {h, g, f, e, d, c, b, a}, 64'h0);
        check("hold_rst_acc", acc_q, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
